ahb_lite_sram_slave: RTL and testbench

AHB-Lite memory slave that sits directly downstream of the team's AHB-Lite master. It decodes pipelined address phases, inserts a configurable number of wait states and stores write data into an internal word array with byte-lane enables. It returns read data and signals errors with the two-cycle AHB-Lite ERROR response. In a single-slave system its HREADYOUT is looped back as the master's HREADY and as this block's HREADY input.

---
 rtl/ahb_lite_sram_slave.sv | 134 +++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite word-array slave with byte-lane writes, programmable wait states
// and the two-cycle ERROR response for illegal or read-only accesses.
module ahb_lite_sram_slave #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1,
  parameter int RO_WORDS    = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [29:0] RO_LIM    = 30'(RO_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [31:0] addr_reg;
  logic        write_reg;
  logic [2:0]  size_reg;
  logic        hreadyout_reg;
  logic        hresp_reg;

  logic             accept;
  logic             addr_err;
  logic             data_done;
  logic             slot_free;
  logic             commit;
  logic [3:0]       lane_en;
  logic [31:0]      rd_word;
  logic [IDX_W-1:0] word_idx;
  logic             unused_ok;

  assign accept    = HSEL && HREADY && HTRANS[1];
  assign data_done = (state_reg == ST_DATA) && (cnt_reg == 4'd0);
  // A new address phase can only be taken where the previous data phase ends.
  assign slot_free = (state_reg == ST_IDLE) || (state_reg == ST_ERR2) || data_done;
  assign commit    = data_done && write_reg;
  assign word_idx  = addr_reg[IDX_W+1:2];

  always_comb begin
    addr_err = 1'b0;
    if (HSIZE > 3'd2)                            addr_err = 1'b1;
    if ((HSIZE == 3'd1) && HADDR[0])             addr_err = 1'b1;
    if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'd0)) addr_err = 1'b1;
    if (HADDR[31:2] >= DEPTH_LIM)                addr_err = 1'b1;
    if (HWRITE && (HADDR[31:2] < RO_LIM))        addr_err = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 4'd0;
      addr_reg      <= 32'd0;
      write_reg     <= 1'b0;
      size_reg      <= 3'd0;
      hreadyout_reg <= 1'b1;
      hresp_reg     <= 1'b0;
    end else if (slot_free) begin
      if (accept) begin
        addr_reg  <= HADDR;
        write_reg <= HWRITE;
        size_reg  <= HSIZE;
        if (addr_err) begin
          state_reg     <= ST_ERR1;
          cnt_reg       <= 4'd0;
          hreadyout_reg <= 1'b0;
          hresp_reg     <= 1'b1;
        end else begin
          state_reg     <= ST_DATA;
          cnt_reg       <= WAIT_INIT;
          hreadyout_reg <= (WAIT_INIT == 4'd0);
          hresp_reg     <= 1'b0;
        end
      end else begin
        state_reg     <= ST_IDLE;
        hreadyout_reg <= 1'b1;
        hresp_reg     <= 1'b0;
      end
    end else if (state_reg == ST_DATA) begin
      cnt_reg       <= cnt_reg - 4'd1;
      hreadyout_reg <= (cnt_reg == 4'd1);
    end else begin
      state_reg     <= ST_ERR2;
      hreadyout_reg <= 1'b1;
      hresp_reg     <= 1'b1;
    end
  end

  always_comb begin
    case (size_reg)
      3'd0:    lane_en = 4'b0001 << addr_reg[1:0];
      3'd1:    lane_en = addr_reg[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // One byte-wide array per lane so each lane's write enable maps onto its own RAM.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge HCLK) begin
        if (commit && lane_en[gi])
          lane_mem[word_idx] <= HWDATA[8*gi +: 8];
      end

      assign rd_word[8*gi +: 8] = lane_mem[word_idx];
    end
  endgenerate

  assign HRDATA    = (data_done && !write_reg) ? rd_word : 32'd0;
  assign HREADYOUT = hreadyout_reg;
  assign HRESP     = hresp_reg;

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], addr_reg[31:IDX_W+2]};

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Randomised and directed bench for ahb_lite_sram_slave: a transfer-level master
// drives two instances (0 and 1 wait states) and a scoreboard memory predicts responses.
module tb_ahb_lite_sram_slave;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = 32'd0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [2:0]  hburst = 3'd0;
  logic [3:0]  hprot = 4'd0;
  logic [1:0]  htrans = 2'd0;
  logic        hmastlock = 1'b0;
  logic [31:0] hwdata = 32'd0;
  int          dsel = 1;

  logic        hsel0, hsel1;
  logic [31:0] hrdata0, hrdata1, hrdata;
  logic        hreadyout0, hreadyout1, hreadyout;
  logic        hresp0, hresp1, hresp;

  assign hsel0     = hsel && (dsel == 0);
  assign hsel1     = hsel && (dsel == 1);
  assign hrdata    = (dsel == 0) ? hrdata0 : hrdata1;
  assign hreadyout = (dsel == 0) ? hreadyout0 : hreadyout1;
  assign hresp     = (dsel == 0) ? hresp0 : hresp1;

  ahb_lite_sram_slave #(.DEPTH_WORDS(256), .WAIT_STATES(0), .RO_WORDS(16)) u_dut_ws0 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock),
    .HREADY(hreadyout0), .HWDATA(hwdata), .HRDATA(hrdata0), .HREADYOUT(hreadyout0),
    .HRESP(hresp0)
  );

  ahb_lite_sram_slave #(.DEPTH_WORDS(256), .WAIT_STATES(1), .RO_WORDS(16)) u_dut_ws1 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel1), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock),
    .HREADY(hreadyout1), .HWDATA(hwdata), .HRDATA(hrdata1), .HREADYOUT(hreadyout1),
    .HRESP(hresp1)
  );

  always #5 hclk = ~hclk;

  int          checks = 0;
  int          failures = 0;
  xfer_t       q[$];
  logic [31:0] last_rd;
  logic [31:0] mdl_mem [2][256];
  logic [3:0]  mdl_known [2][256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic xfer_t mk(input logic wr, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] wdata);
    xfer_t x;
    x.sel = 1'b1; x.trans = 2'd2; x.addr = addr; x.wr = wr; x.size = size; x.wdata = wdata;
    return x;
  endfunction

  function automatic bit mdl_is_err(input xfer_t x);
    int sz = int'(x.size);
    return (sz > 2) || (sz == 1 && x.addr % 2 != 0) || (sz == 2 && x.addr % 4 != 0) ||
           (x.addr >= 32'd1024) || (x.wr && (x.addr / 4) < 16);
  endfunction

  task automatic mdl_write(input int s, input xfer_t x);
    int idx = int'(x.addr / 4);
    int off = int'(x.addr % 4);
    int nb  = 1 << int'(x.size);
    for (int b = off; b < off + nb; b++) begin
      mdl_mem[s][idx][8*b +: 8] = x.wdata[8*b +: 8];
      mdl_known[s][idx][b] = 1'b1;
    end
  endtask

  // Bytes never written through the bus are learned on first read, then held to.
  task automatic mdl_read(input int s, input logic [31:0] addr, input logic [31:0] obs,
                          output logic [31:0] exp);
    int idx = int'(addr / 4);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{mdl_known[s][idx][b]}};
    exp = (mdl_mem[s][idx] & m) | (obs & ~m);
    mdl_mem[s][idx] = exp;
    mdl_known[s][idx] = 4'hF;
  endtask

  task automatic drive_idle();
    hsel = 1'b0; htrans = 2'd0; haddr = 32'd0; hwrite = 1'b0; hsize = 3'd0;
  endtask

  // Plays the queue through instance s as a pipelined master; called at posedge+1.
  task automatic run_queue(input int s);
    int          ws = (s == 0) ? 0 : 1;
    bit          have_dp = 0;
    bit          dp_err = 0;
    int          k = 0;
    int          cyc = 0;
    xfer_t       dp;
    xfer_t       x;
    logic        exp_rdy, exp_resp;
    logic [31:0] exp_rd;
    dsel = s;
    #0;
    while ((q.size() > 0 || have_dp) && cyc < 3000) begin
      exp_rdy = 1'b1; exp_resp = 1'b0; exp_rd = 32'd0;
      if (have_dp) begin
        if (dp_err) begin
          exp_rdy = (k == 1); exp_resp = 1'b1;
        end else begin
          exp_rdy = (k == ws);
          if (exp_rdy && !dp.wr) mdl_read(s, dp.addr, hrdata, exp_rd);
        end
      end
      chk($sformatf("i%0d_hreadyout", s), {31'd0, hreadyout}, {31'd0, exp_rdy});
      chk($sformatf("i%0d_hresp", s), {31'd0, hresp}, {31'd0, exp_resp});
      chk($sformatf("i%0d_hrdata", s), hrdata, exp_rd);
      if (have_dp && exp_rdy) begin
        if (!dp_err && !dp.wr) last_rd = hrdata;
        $display("xfer inst=%0d %s addr=%08h size=%0d resp=%0d rdata=%08h",
                 s, dp.wr ? "WR" : "RD", dp.addr, dp.size, dp_err, hrdata);
      end
      if (q.size() > 0) begin
        hsel = q[0].sel; htrans = q[0].trans; haddr = q[0].addr;
        hwrite = q[0].wr; hsize = q[0].size;
      end else begin
        drive_idle();
      end
      hwdata    = (have_dp && dp.wr) ? dp.wdata : $urandom;
      hburst    = 3'($urandom_range(0, 7));
      hprot     = 4'($urandom_range(0, 15));
      hmastlock = 1'($urandom_range(0, 1));
      @(posedge hclk); #1;
      cyc++;
      if (exp_rdy) begin
        if (have_dp && !dp_err && dp.wr) mdl_write(s, dp);
        have_dp = 0;
        if (q.size() > 0) begin
          x = q.pop_front();
          if (x.sel && x.trans[1]) begin
            dp = x; have_dp = 1; k = 0; dp_err = mdl_is_err(x);
          end
        end
      end else begin
        k++;
      end
    end
    if (cyc >= 3000) chk($sformatf("i%0d_timeout", s), 32'd1, 32'd0);
    drive_idle();
  endtask

  function automatic xfer_t rand_xfer();
    xfer_t x;
    int r = $urandom_range(0, 99);
    int idx;
    int off;
    x.sel = 1'b1;
    x.trans = 2'($urandom_range(2, 3));
    if (r < 8)       x.trans = 2'd0;
    else if (r < 14) x.trans = 2'd1;
    else if (r < 20) x.sel = 1'b0;
    r = $urandom_range(0, 99);
    if (r < 70)      idx = $urandom_range(16, 31);
    else if (r < 80) idx = $urandom_range(0, 15);
    else if (r < 90) idx = $urandom_range(250, 300);
    else             idx = $urandom_range(32, 255);
    x.size = (($urandom_range(0, 99)) < 5) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    if ($urandom_range(0, 99) < 85) begin
      if (x.size == 3'd0)      off = $urandom_range(0, 3);
      else if (x.size == 3'd1) off = 2 * $urandom_range(0, 1);
      else                     off = 0;
    end else begin
      off = $urandom_range(0, 3);
    end
    x.addr  = 32'(idx * 4 + off);
    x.wr    = 1'($urandom_range(0, 1));
    x.wdata = $urandom;
    return x;
  endfunction

  initial begin
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) begin
        mdl_mem[s][i] = 32'd0;
        mdl_known[s][i] = 4'h0;
      end
    last_rd = 32'd0;

    repeat (3) @(posedge hclk);
    #1;
    chk("rst_hreadyout0", {31'd0, hreadyout0}, 32'd1);
    chk("rst_hresp0", {31'd0, hresp0}, 32'd0);
    chk("rst_hrdata0", hrdata0, 32'd0);
    chk("rst_hreadyout1", {31'd0, hreadyout1}, 32'd1);
    chk("rst_hresp1", {31'd0, hresp1}, 32'd0);
    chk("rst_hrdata1", hrdata1, 32'd0);
    hresetn = 1'b1;
    @(posedge hclk); #1;

    for (int i = 0; i < 5; i++) begin
      q.push_back(mk(1'b0, 32'h0, 3'd2, 32'h0));
      q[$].trans = 2'd0;
    end
    run_queue(1);

    q.push_back(mk(1'b1, 32'h40, 3'd2, 32'hDEADBEEF));
    q.push_back(mk(1'b0, 32'h40, 3'd2, 32'h0));
    run_queue(1);
    chk("rd_0x40", last_rd, 32'hDEADBEEF);

    q.push_back(mk(1'b1, 32'h44, 3'd2, 32'h11223344));
    q.push_back(mk(1'b1, 32'h45, 3'd0, 32'h0000AA00));
    q.push_back(mk(1'b1, 32'h46, 3'd1, 32'hBBBB0000));
    q.push_back(mk(1'b0, 32'h44, 3'd2, 32'h0));
    run_queue(1);
    chk("rd_0x44_merge", last_rd, 32'hBBBBAA44);

    q.push_back(mk(1'b1, 32'h80, 3'd2, 32'h5));
    q.push_back(mk(1'b0, 32'h80, 3'd2, 32'h0));
    run_queue(0);
    chk("rd_0x80_ws0", last_rd, 32'h5);

    q.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
    q.push_back(mk(1'b1, 32'h10, 3'd2, 32'hCAFEF00D));
    q.push_back(mk(1'b0, 32'h42, 3'd2, 32'h0));
    q.push_back(mk(1'b0, 32'h400, 3'd2, 32'h0));
    q.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
    run_queue(1);

    q.push_back(mk(1'b1, 32'h50, 3'd2, 32'h0));
    run_queue(1);
    hsel = 1'b1; htrans = 2'd2; haddr = 32'h50; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    drive_idle();
    hwdata = 32'h12345678;
    chk("rst_mid_wait", {31'd0, hreadyout1}, 32'd0);
    #2 hresetn = 1'b0;
    #1;
    chk("rst_async_hreadyout", {31'd0, hreadyout1}, 32'd1);
    chk("rst_async_hresp", {31'd0, hresp1}, 32'd0);
    chk("rst_async_hrdata", hrdata1, 32'd0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    q.push_back(mk(1'b0, 32'h50, 3'd2, 32'h0));
    run_queue(1);
    chk("rd_0x50_after_rst", last_rd, 32'h0);

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 150; i++) q.push_back(rand_xfer());
      run_queue(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
